sent_tx_symbol_gen: RTL and testbench

SENT_TX_SYMBOL_GEN -- requirements
Module: sent_tx_symbol_gen

---
 rtl/sent_tx_pkg.sv | 24 ++
 rtl/sent_tx_frame_acc.sv | 47 ++++
 rtl/sent_tx_symbol_gen.sv | 150 +++++++++++++++
 tb/tb_sent_tx_symbol_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sent_tx_pkg.sv
// Shared types and default parameter constants for the SENT transmit symbol generator.
// Pause support in the generator is compiled in with macro SENT_TX_PAUSE_EN.
package sent_tx_pkg;

    localparam int DEF_LOW_TICKS   = 5;
    localparam int DEF_SYNC_TICKS  = 56;
    localparam int DEF_NIB_OFFSET  = 12;
    localparam int DEF_FRAME_TICKS = 282;
    localparam int DEF_CNT_W       = 10;

    typedef enum logic [1:0] {
        SYM_SYNC  = 2'd0,
        SYM_DATA  = 2'd1,
        SYM_PAUSE = 2'd2,
        SYM_RSVD  = 2'd3
    } sym_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH
    } tx_state_e;

endpackage

// File: rtl/sent_tx_frame_acc.sv
// Frame-length accumulator and pause-length computation; only built when SENT_TX_PAUSE_EN is defined.
module sent_tx_frame_acc
    import sent_tx_pkg::*;
#(
    parameter int SYNC_TICKS  = DEF_SYNC_TICKS,
    parameter int NIB_OFFSET  = DEF_NIB_OFFSET,
    parameter int FRAME_TICKS = DEF_FRAME_TICKS,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept_i,
    input  sym_type_e        sym_type_i,
    input  logic [CNT_W-1:0] data_len_i,
    output logic [CNT_W-1:0] pause_len_o,
    output logic             clamp_o
);

    logic [CNT_W-1:0]        acc_q, acc_d;
    logic signed [CNT_W:0]   room;
    logic [CNT_W:0]          sum;

    // One extra signed bit so an overfull frame yields a negative room instead of wrapping.
    assign room        = $signed((CNT_W+1)'(FRAME_TICKS)) - $signed({1'b0, acc_q});
    assign clamp_o     = room < $signed((CNT_W+1)'(NIB_OFFSET));
    assign pause_len_o = clamp_o ? CNT_W'(NIB_OFFSET) : room[CNT_W-1:0];
    assign sum         = {1'b0, acc_q} + {1'b0, data_len_i};

    always_comb begin
        // NOTE: default assignment first so no path leaves acc_d unassigned (no latch).
        acc_d = acc_q;
        if (accept_i) begin
            case (sym_type_i)
                SYM_SYNC:  acc_d = CNT_W'(SYNC_TICKS);
                SYM_DATA:  acc_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
                SYM_PAUSE: acc_d = '0;
                default:   acc_d = acc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

endmodule

// File: rtl/sent_tx_symbol_gen.sv
// SENT transmit symbol generator: each symbol is a fixed low phase followed by a high phase.
// Define SENT_TX_PAUSE_EN to compile in pause symbols and the frame accumulator.
module sent_tx_symbol_gen
    import sent_tx_pkg::*;
#(
    parameter int LOW_TICKS   = DEF_LOW_TICKS,
    parameter int SYNC_TICKS  = DEF_SYNC_TICKS,
    parameter int NIB_OFFSET  = DEF_NIB_OFFSET,
    parameter int FRAME_TICKS = DEF_FRAME_TICKS,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       ticks,
    input  logic       reset_tx_n,
    input  logic       sym_valid,
    input  logic [1:0] sym_type,
    input  logic [3:0] data_nibble,
    output logic       sym_ready,
    output logic       sym_done,
    output logic       sym_err,
    output logic       pause_clamped,
    output logic       busy,
    output logic       data_pulse
);

    if (LOW_TICKS >= NIB_OFFSET) begin : g_chk_low
        $error("LOW_TICKS must be smaller than NIB_OFFSET");
    end
    if (FRAME_TICKS >= (1 << CNT_W)) begin : g_chk_frame
        $error("FRAME_TICKS must fit in CNT_W bits");
    end

    tx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q, hi_len_q, hi_len_d;
    logic             ready_q, done_q, err_q, busy_q, pulse_q;

    logic             accept, req_ok, clamp;
    sym_type_e        req_type;
    logic [CNT_W-1:0] req_len;

    assign accept   = reset_tx_n && sym_valid && ready_q;
    assign req_type = sym_type_e'(sym_type);

`ifdef SENT_TX_PAUSE_EN
    logic [CNT_W-1:0] pause_len;

    sent_tx_frame_acc #(
        .SYNC_TICKS  (SYNC_TICKS),
        .NIB_OFFSET  (NIB_OFFSET),
        .FRAME_TICKS (FRAME_TICKS),
        .CNT_W       (CNT_W)
    ) u_frame_acc (
        .clk         (ticks),
        .rst_n       (reset_tx_n),
        .accept_i    (accept),
        .sym_type_i  (req_type),
        .data_len_i  (req_len),
        .pause_len_o (pause_len),
        .clamp_o     (clamp)
    );
`else
    assign clamp = 1'b0;
`endif

    always_comb begin
        req_ok  = 1'b1;
        req_len = CNT_W'(SYNC_TICKS);
        case (req_type)
            SYM_SYNC:  req_len = CNT_W'(SYNC_TICKS);
            SYM_DATA:  req_len = CNT_W'(NIB_OFFSET) + CNT_W'(data_nibble);
`ifdef SENT_TX_PAUSE_EN
            SYM_PAUSE: req_len = pause_len;
`endif
            default:   req_ok  = 1'b0;
        endcase
        hi_len_d = req_len - CNT_W'(LOW_TICKS);
    end

    // Strobe rides the acceptance cycle itself, so it is decoded rather than registered.
    assign pause_clamped = accept && (req_type == SYM_PAUSE) && clamp;

    always_ff @(posedge ticks) begin
        if (!reset_tx_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_len_q <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            pulse_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: ready_q <= 1'b1;
                ST_LOW: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= hi_len_q - CNT_W'(1);
                        pulse_q <= 1'b1;
                        if (hi_len_q == CNT_W'(1)) begin
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        // Next cycle is the last high tick: open the window for a back-to-back request.
                        if (cnt_q == CNT_W'(1)) begin
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (accept) begin
                if (req_ok) begin
                    state_q  <= ST_LOW;
                    cnt_q    <= CNT_W'(LOW_TICKS - 1);
                    hi_len_q <= hi_len_d;
                    pulse_q  <= 1'b0;
                    busy_q   <= 1'b1;
                    ready_q  <= 1'b0;
                end else begin
                    state_q <= ST_IDLE;
                    err_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    pulse_q <= 1'b1;
                end
            end
        end
    end

    assign sym_ready  = ready_q;
    assign sym_done   = done_q;
    assign sym_err    = err_q;
    assign busy       = busy_q;
    assign data_pulse = pulse_q;

endmodule

// File: tb/tb_sent_tx_symbol_gen.sv
// Directed bench for sent_tx_symbol_gen; pause scenarios follow SENT_TX_PAUSE_EN.
module tb_sent_tx_symbol_gen;

    logic       ticks = 1'b0;
    logic       reset_tx_n;
    logic       sym_valid;
    logic [1:0] sym_type;
    logic [3:0] data_nibble;
    logic       sym_ready, sym_done, sym_err, pause_clamped, busy, data_pulse;

    int checks = 0;
    int errors = 0;

    always #5 ticks = ~ticks;

    sent_tx_symbol_gen dut (
        .ticks         (ticks),
        .reset_tx_n    (reset_tx_n),
        .sym_valid     (sym_valid),
        .sym_type      (sym_type),
        .data_nibble   (data_nibble),
        .sym_ready     (sym_ready),
        .sym_done      (sym_done),
        .sym_err       (sym_err),
        .pause_clamped (pause_clamped),
        .busy          (busy),
        .data_pulse    (data_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ticks);
        #1;
    endtask

    // Requests one symbol and measures its low/high phases up to and including the sym_done cycle.
    // Returns in the sym_done cycle so a following call is accepted back-to-back.
    task automatic emit(input logic [1:0] ty, input logic [3:0] nib,
                        output int lo, output int hi, output logic pc);
        int guard;
        lo = 0;
        hi = 0;
        guard = 0;
        while (!sym_ready && guard < 200) begin
            step();
            guard++;
        end
        sym_valid   = 1'b1;
        sym_type    = ty;
        data_nibble = nib;
        #1;
        pc = pause_clamped;
        step();
        sym_valid   = 1'b0;
        sym_type    = 2'd3;
        data_nibble = ~nib;
        check("latency1_low", data_pulse, 1'b0);
        guard = 0;
        while (guard < 400) begin
            if (data_pulse) hi++;
            else            lo++;
            if (sym_done) break;
            step();
            guard++;
        end
        check("sym_done_seen", sym_done, 1'b1);
        check("ready_with_done", sym_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lo, hi;
        logic pc;

        reset_tx_n  = 1'b0;
        sym_valid   = 1'b0;
        sym_type    = 2'd0;
        data_nibble = 4'd0;
        repeat (3) step();
        check("rst_pulse", data_pulse, 1'b1);
        check("rst_ready", sym_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", sym_done, 1'b0);
        check("rst_err", sym_err, 1'b0);
        check("rst_clamp", pause_clamped, 1'b0);
        reset_tx_n = 1'b1;
        step();
        check("ready_after_rst", sym_ready, 1'b1);

        // SYNC after reset: 5 low + 51 high
        emit(2'd0, 4'd0, lo, hi, pc);
        check("sync_low", lo, 5);
        check("sync_high", hi, 51);

        // Back-to-back DATA 0 and 15 (zero gap checked by latency1_low)
        emit(2'd1, 4'd0, lo, hi, pc);
        check("nib0_low", lo, 5);
        check("nib0_high", hi, 7);
        emit(2'd1, 4'd15, lo, hi, pc);
        check("nib15_low", lo, 5);
        check("nib15_high", hi, 22);

        // No further request: line returns to idle high
        step();
        check("idle_pulse", data_pulse, 1'b1);
        check("idle_busy", busy, 1'b0);
        check("idle_ready", sym_ready, 1'b1);
        check("idle_done_clear", sym_done, 1'b0);

        // Reserved type is consumed and rejected
        sym_valid = 1'b1;
        sym_type  = 2'd3;
        step();
        sym_valid = 1'b0;
        check("rsvd_err", sym_err, 1'b1);
        check("rsvd_pulse", data_pulse, 1'b1);
        check("rsvd_busy", busy, 1'b0);
        step();
        check("rsvd_err_1cyc", sym_err, 1'b0);
        check("rsvd_ready", sym_ready, 1'b1);
        check("rsvd_pulse2", data_pulse, 1'b1);

`ifdef SENT_TX_PAUSE_EN
        // SYNC + 6x DATA15 = 218 -> pause 64
        emit(2'd0, 4'd0, lo, hi, pc);
        for (int i = 0; i < 6; i++) emit(2'd1, 4'd15, lo, hi, pc);
        emit(2'd2, 4'd0, lo, hi, pc);
        check("pause64_len", lo + hi, 64);
        check("pause64_low", lo, 5);
        check("pause64_noclamp", pc, 1'b0);
        // acc cleared by the pause, so a lone pause fills the whole frame
        emit(2'd2, 4'd0, lo, hi, pc);
        check("pause_acc0_len", lo + hi, 282);
        check("pause_acc0_noclamp", pc, 1'b0);

        // SYNC + 9x DATA15 = 299 -> clamped to 12
        emit(2'd0, 4'd0, lo, hi, pc);
        for (int i = 0; i < 9; i++) emit(2'd1, 4'd15, lo, hi, pc);
        emit(2'd2, 4'd0, lo, hi, pc);
        check("pause_clamp_len", lo + hi, 12);
        check("pause_clamp_pulse", pc, 1'b1);
        step();
        check("pause_clamp_idle", pause_clamped, 1'b0);
`else
        // Pause compiled out: type 2 behaves like the reserved type
        sym_valid = 1'b1;
        sym_type  = 2'd2;
        #1;
        check("nopause_clamp", pause_clamped, 1'b0);
        step();
        sym_valid = 1'b0;
        check("nopause_err", sym_err, 1'b1);
        check("nopause_pulse", data_pulse, 1'b1);
        check("nopause_busy", busy, 1'b0);
        step();
        check("nopause_err_1cyc", sym_err, 1'b0);
`endif

        // Reset in the high phase of a SYNC (tick 20)
        sym_valid = 1'b1;
        sym_type  = 2'd0;
        step();
        sym_valid = 1'b0;
        repeat (19) step();
        check("mid_busy", busy, 1'b1);
        check("mid_high", data_pulse, 1'b1);
        reset_tx_n = 1'b0;
        step();
        check("midrst_pulse", data_pulse, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", sym_ready, 1'b0);
        check("midrst_done", sym_done, 1'b0);
        reset_tx_n = 1'b1;
        step();
        check("midrst_ready_up", sym_ready, 1'b1);
        emit(2'd0, 4'd0, lo, hi, pc);
        check("resync_low", lo, 5);
        check("resync_high", hi, 51);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
